// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer run-control logic.
package countdown_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MSG_MIN      = 4'hA;
  localparam logic [DIGIT_W-1:0] MIN_PRESET   = 4'd5;
  localparam logic [DIGIT_W-1:0] SEG2_PRESET  = 4'd0;
  localparam logic [DIGIT_W-1:0] SEG1_PRESET  = 4'd0;
  localparam logic [DIGIT_W-1:0] DECI_PRESET  = 4'd0;
  localparam logic [DIGIT_W-1:0] CENTI_PRESET = 4'd0;
  localparam logic [DIGIT_W-1:0] MILLI_PRESET = 4'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running modulo-DIV counter; tick flags the cycle whose edge wraps it back to 0.
module tick_prescaler #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  assign tick = run && (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_cnt <= '0;
    end else if (run) begin
      r_cnt <= tick ? '0 : r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Run-control sequencer: start/pause/clear handling, 1 ms tick generation,
// expiry detection and timed buzzer for the 6-digit countdown timer.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int BUZZ_TICKS = 2000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               btn_clear,
  input  logic [DIGIT_W-1:0] min,
  input  logic [DIGIT_W-1:0] seg2,
  input  logic [DIGIT_W-1:0] seg1,
  input  logic [DIGIT_W-1:0] deci,
  input  logic [DIGIT_W-1:0] centi,
  input  logic [DIGIT_W-1:0] milli,
  output logic               cnt_enable,
  output logic               cnt_reset,
  output logic               running,
  output logic               paused,
  output logic               expired,
  output logic               buzzer
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int BW  = (BUZZ_TICKS > 0) ? $clog2(BUZZ_TICKS + 1) : 1;
  localparam logic [BW-1:0] BUZZ_MAX = BW'(BUZZ_TICKS);

  state_t        r_state, w_next;
  logic          w_zero_det, w_msg_det, w_done;
  logic          w_tick, w_pre_run, w_pre_clr;
  logic [BW-1:0] r_buzz_cnt, w_buzz_next;
  logic          r_cnt_enable, r_cnt_reset, r_buzzer;
  logic          r_running, r_paused, r_expired;

  assign w_zero_det = ({min, seg2, seg1, deci, centi, milli} == '0);
  assign w_msg_det  = (min == MSG_MIN);
  assign w_done     = w_zero_det || w_msg_det;

  always_comb begin
    w_next = r_state;
    if (btn_clear) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (btn_start && !w_done) w_next = RUNNING;
        RUNNING: begin
          if (w_done)         w_next = EXPIRED;
          else if (btn_pause) w_next = PAUSED;
        end
        PAUSED:  if (btn_start) w_next = RUNNING;
        EXPIRED: w_next = EXPIRED;
        default: w_next = IDLE;
      endcase
    end
  end

  // The prescaler only advances on edges that keep the state, so a pause or
  // expiry edge never produces a tick and the resume phase is preserved.
  assign w_pre_run = (w_next == r_state) && ((r_state == RUNNING) || (r_state == EXPIRED));
  assign w_pre_clr = btn_clear ||
                     ((w_next != r_state) && ((w_next == IDLE) || (w_next == EXPIRED)));

  tick_prescaler #(.DIV(DIV)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (w_pre_clr),
    .run   (w_pre_run),
    .tick  (w_tick)
  );

  always_comb begin
    w_buzz_next = r_buzz_cnt;
    if ((r_state == EXPIRED) && w_tick && (r_buzz_cnt != BUZZ_MAX)) begin
      w_buzz_next = r_buzz_cnt + BW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_cnt_enable <= 1'b0;
      r_cnt_reset  <= 1'b1;
      r_buzz_cnt   <= '0;
      r_buzzer     <= 1'b0;
      r_running    <= 1'b0;
      r_paused     <= 1'b0;
      r_expired    <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt_reset  <= btn_clear;
      r_cnt_enable <= w_tick && (r_state == RUNNING);
      r_running    <= (w_next == RUNNING);
      r_paused     <= (w_next == PAUSED);
      r_expired    <= (w_next == EXPIRED);
      if (btn_clear) begin
        r_buzz_cnt <= '0;
        r_buzzer   <= 1'b0;
      end else if ((w_next == EXPIRED) && (r_state != EXPIRED)) begin
        r_buzz_cnt <= '0;
        r_buzzer   <= 1'b1;
      end else if (r_state == EXPIRED) begin
        r_buzz_cnt <= w_buzz_next;
        r_buzzer   <= (w_buzz_next != BUZZ_MAX);
      end
    end
  end

  assign cnt_enable = r_cnt_enable;
  assign cnt_reset  = r_cnt_reset;
  assign running    = r_running;
  assign paused     = r_paused;
  assign expired    = r_expired;
  assign buzzer     = r_buzzer;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Bench for countdown_ctrl with an attached millisecond timer model and a cycle-level reference.
module tb_countdown_ctrl;
  import countdown_pkg::*;

  localparam int CLK_HZ     = 10;
  localparam int TICK_HZ    = 1;
  localparam int BUZZ_TICKS = 3;
  localparam int DIV        = CLK_HZ / TICK_HZ;
  localparam int PRESET_MS  = 300000;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic clk = 1'b0;
  logic reset, btn_start, btn_pause, btn_clear;
  logic [3:0] min, seg2, seg1, deci, centi, milli;
  logic cnt_enable, cnt_reset, running, paused, expired, buzzer;

  always #5 clk = ~clk;

  countdown_ctrl #(
    .CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .BUZZ_TICKS(BUZZ_TICKS)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_start(btn_start), .btn_pause(btn_pause), .btn_clear(btn_clear),
    .min(min), .seg2(seg2), .seg1(seg1), .deci(deci), .centi(centi), .milli(milli),
    .cnt_enable(cnt_enable), .cnt_reset(cnt_reset),
    .running(running), .paused(paused), .expired(expired), .buzzer(buzzer)
  );

  // Timer model: remaining time in ms, switching to the message once at zero.
  int t_val;
  bit t_msg;

  always_comb begin
    if (t_msg) begin
      min = MSG_MIN; seg2 = 4'hB; seg1 = 4'hC; deci = 4'hC; centi = 4'h0; milli = 4'h0;
    end else begin
      min   = 4'(t_val / 60000);
      seg2  = 4'(((t_val / 1000) % 60) / 10);
      seg1  = 4'((t_val / 1000) % 10);
      deci  = 4'((t_val / 100) % 10);
      centi = 4'((t_val / 10) % 10);
      milli = 4'(t_val % 10);
    end
  end

  int  m_mode, m_run_cyc, m_exp_cyc;
  bit  e_en, e_rst, e_buz;
  int  total, bad, cyc;
  int  n_en, first_en, last_en, n_buz;

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d: got %0b expected %0b", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit st, input bit pa, input bit cl);
    bit pre_en, pre_rst, done;
    reset = rs; btn_start = st; btn_pause = pa; btn_clear = cl;
    done    = t_msg || (t_val == 0);
    pre_en  = (cnt_enable === 1'b1);
    pre_rst = (cnt_reset === 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    e_en  = 1'b0;
    e_rst = 1'b0;
    if (rs || cl) begin
      m_mode = M_IDLE; e_rst = 1'b1; m_run_cyc = 0; e_buz = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE:  if (st && !done) m_mode = M_RUN;
        M_RUN: begin
          if (done) begin
            m_mode = M_EXP; m_exp_cyc = 0; e_buz = 1'b1;
          end else if (pa) begin
            m_mode = M_PAUSE;
          end else begin
            m_run_cyc++;
            e_en = (m_run_cyc % DIV) == 0;
          end
        end
        M_PAUSE: if (st) m_mode = M_RUN;
        default: begin
          m_exp_cyc++;
          e_buz = m_exp_cyc < BUZZ_TICKS * DIV;
        end
      endcase
    end
    if (pre_rst) begin
      t_val = PRESET_MS; t_msg = 1'b0;
    end else if (pre_en && t_val > 0) begin
      t_val--;
    end else if (t_val == 0) begin
      t_msg = 1'b1;
    end
    if (cnt_enable === 1'b1) begin
      n_en++;
      if (first_en == 0) first_en = cyc + 1;
      last_en = cyc + 1;
    end
    if (buzzer === 1'b1) n_buz++;
    chk("cnt_enable", cnt_enable, e_en);
    chk("cnt_reset",  cnt_reset,  e_rst);
    chk("running",    running,    m_mode == M_RUN);
    chk("paused",     paused,     m_mode == M_PAUSE);
    chk("expired",    expired,    m_mode == M_EXP);
    chk("buzzer",     buzzer,     e_buz);
  endtask

  task automatic reset_seq();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    cyc = 0; n_en = 0; first_en = 0; last_en = 0; n_buz = 0;
  endtask

  initial begin
    reset = 1'b1; btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0;
    t_val = int'(MIN_PRESET) * 60000; t_msg = 1'b0;
    m_mode = M_IDLE; m_run_cyc = 0; m_exp_cyc = 0;
    e_en = 1'b0; e_rst = 1'b1; e_buz = 1'b0;
    total = 0; bad = 0; cyc = 0;

    // Start at cycle 5, three ticks.
    reset_seq();
    for (int c = 1; c <= 37; c++) step(0, c == 5, 0, 0);
    chk_int("t1_tick_count", n_en, 3);
    chk_int("t1_first_tick", first_en, 16);
    chk_int("t1_third_tick", last_en, 36);
    chk_int("t1_digits", t_val, 299997);

    // Pause at 23, resume at 40: phase kept.
    reset_seq();
    for (int c = 1; c <= 45; c++) step(0, (c == 5) || (c == 40), c == 23, 0);
    chk_int("t2_tick_count", n_en, 2);
    chk_int("t2_resume_tick", last_en, 44);

    // Preload 0:00.002, expire, buzzer for BUZZ_TICKS*DIV cycles.
    reset_seq();
    for (int c = 1; c <= 12; c++) step(0, c == 1, 0, 0);
    t_val = 2;
    n_en = 0;
    for (int c = 13; c <= 75; c++) step(0, 0, c == 50, 0);
    chk_int("t3_ticks_to_zero", n_en, 2);
    chk_int("t3_buzz_cycles", n_buz, BUZZ_TICKS * DIV);
    chk("t3_msg_shown", t_msg, 1'b1);

    // Clear during EXPIRED with buzzer on.
    reset_seq();
    step(0, 1, 0, 0);
    t_val = 1;
    for (int c = 0; c < 20; c++) step(0, 0, 0, 0);
    chk("t4_buzz_before_clear", buzzer, 1'b1);
    step(0, 1, 1, 1);
    step(0, 0, 0, 0);
    chk_int("t4_reload", t_val, PRESET_MS);
    chk("t4_msg_off", t_msg, 1'b0);
    for (int c = 0; c < 5; c++) step(0, 0, 1, 0);

    // Simultaneous start+pause from IDLE then from RUNNING.
    reset_seq();
    step(0, 1, 1, 0);
    chk("t5_idle_start_wins", running, 1'b1);
    step(0, 0, 0, 0);
    step(0, 1, 1, 0);
    chk("t5_run_pause_wins", paused, 1'b1);
    step(0, 1, 1, 0);
    chk("t5_paused_start_wins", running, 1'b1);

    // Reset mid-run for two cycles.
    reset_seq();
    for (int c = 0; c < 20; c++) step(0, c == 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    n_en = 0;
    for (int c = 0; c < 30; c++) step(0, 0, c == 10, 0);
    chk_int("t6_no_tick_after_reset", n_en, 0);

    // Random traffic against the reference.
    reset_seq();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        t_val = int'($urandom_range(0, 5));
        t_msg = 1'b0;
      end
      step($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 11) == 0, $urandom_range(0, 59) == 0);
    end

    btn_start = 1'b0; btn_pause = 1'b0; btn_clear = 1'b0; reset = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
Name: countdown_ctrl

Overview:
Run-control sequencer for the 6-digit countdown timer (min, seg2, seg1, deci, centi, milli; 5:00.000 preset).
- Turns debounced start/pause/clear pulses into the timer's cnt_reset and 1 ms cnt_enable tick.
- Watches the digit outputs for expiry, then freezes the timer and drives a timed buzzer.
- Sits between the button debouncers and the countdown datapath.

Parameters:
CLK_HZ, 50000000, system clock frequency.
TICK_HZ, 1000, cnt_enable rate; DIV = CLK_HZ/TICK_HZ, must be an integer of at least 2.
BUZZ_TICKS, 2000, buzzer on-time in ticks after expiry.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
btn_start  in  1  one-cycle pulse: start or resume.
btn_pause  in  1  one-cycle pulse: pause.
btn_clear  in  1  one-cycle pulse: abort and reload preset.
min, seg2, seg1, deci, centi, milli  in  4 each  live digits from the timer.
cnt_enable  out  1  one-cycle decrement strobe to the timer.
cnt_reset  out  1  one-cycle reload strobe to the timer.
running, paused, expired  out  1 each  one-hot status.
buzzer  out  1  alarm drive.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, prescaler 0, buzz counter 0, cnt_enable 0, cnt_reset 1, running/paused/expired/buzzer 0.
- cnt_reset is high for exactly one cycle:
  - in the first clock after reset deasserts;
  - in the clock after btn_clear is accepted.
- Detection terms:
  - zero_det: all six digits are 0.
  - msg_det: min == 4'hA, i.e. the timer is showing its expiry message.
  - done = zero_det | msg_det.
- States are IDLE, RUNNING, PAUSED and EXPIRED. The state register updates on the clock edge that samples the input.
- Transitions:
  - IDLE: btn_start with !done goes to RUNNING. btn_start with done is ignored. btn_pause is ignored.
  - RUNNING: done goes to EXPIRED. Otherwise btn_pause goes to PAUSED.
  - PAUSED: btn_start goes to RUNNING.
  - EXPIRED: start and pause are ignored. Only clear or reset leaves this state.
- Priority: reset > btn_clear > done > btn_pause > btn_start.
- btn_clear in any state: goes to IDLE, zeroes the prescaler and buzz counter, forces buzzer 0, and pulses cnt_reset.
- Prescaler (width clog2(DIV)):
  - Increments every cycle in RUNNING and wraps DIV-1 -> 0.
  - cnt_enable is high in the cycle after the wrap edge.
  - Frozen in PAUSED, so resume keeps the phase.
  - Zeroed on entry to IDLE.
  - Also runs in EXPIRED to time the buzzer; cnt_enable stays 0 there.
- Tick latency: btn_start sampled at edge E gives the first cnt_enable in the cycle after edge E+DIV, then every DIV cycles.
- cnt_enable is never high in IDLE, PAUSED or EXPIRED, including the cycle in which done or btn_pause is sampled. This stops the timer counting down through its message codes.
- On entry to EXPIRED:
  - buzzer = 1 and the buzz counter is zeroed.
  - The buzz counter increments on each prescaler wrap. buzzer drops when the counter reaches BUZZ_TICKS.
  - The counter saturates, so there is no re-trigger.
- Status outputs: running, paused and expired mirror the state. All are 0 in IDLE.
- Simultaneous btn_start and btn_pause:
  - in IDLE, start wins;
  - in RUNNING, pause wins;
  - in PAUSED, start wins.
- Reset mid-operation has the same effect as a clear, plus the reset values listed above.

Decomposition:
- Shared package countdown_pkg holds:
  - the state enum (IDLE, RUNNING, PAUSED, EXPIRED);
  - DIGIT_W = 4;
  - MSG_MIN = 4'hA and the preset constants (MIN_PRESET = 5).
- One sub-module, tick_prescaler.
  - Parameter DIV.
  - Ports: clk, reset, clr, run, tick.
  - Reused for the 1 ms strobe and the buzzer timebase.

Test Plan:
Bench parameters: DIV = 10 (CLK_HZ=10, TICK_HZ=1), BUZZ_TICKS=3, timer model attached.
1. Reset, then btn_start at cycle 5 -> cnt_reset at cycle 1 only; running=1 from cycle 6; cnt_enable pulses at cycles 16, 26, 36; digits read 4:59.997 after the third pulse.
2. btn_pause at cycle 23, btn_start at cycle 40 -> no cnt_enable during 24..40; the next pulse comes 3 cycles after resume (prescaler phase kept), at cycle 44.
3. Timer preloaded to 0:00.002 while running -> two ticks to 0:00.000; EXPIRED the next cycle; cnt_enable stays 0 while digits show A,B,C,C,0,0; buzzer=1 for exactly 30 cycles.
4. btn_clear during EXPIRED with buzzer=1 -> buzzer 0 and state IDLE next cycle; one cnt_reset pulse; digits 5:00.000; btn_pause then has no effect.
5. btn_start and btn_pause in the same cycle, from IDLE then from RUNNING -> IDLE goes to RUNNING; RUNNING goes to PAUSED.
6. reset asserted mid-RUNNING for 2 cycles -> all outputs at reset values; one cnt_reset pulse after deassert; no cnt_enable until the next btn_start.
